// File: rtl/fphub_div_result_queue.sv
// ---------------------------------------------------------------------------------------------
// fphub_div_result_queue
//
// Output stage behind the HUB-format divider. The divider emits a one-cycle finish pulse with
// its result and has no backpressure. This block captures each result, with status flags and
// the tag of the op that produced it, into a small FIFO. The FIFO presents the result on a
// valid/ready interface.
//
// Only one divide can be in flight. A tracker FSM follows that op from issue to finish. The
// credit output keeps the number of queued results plus the in-flight op at or below DEPTH,
// so a finish pulse always has a free slot. If a flush arrives while an op is in flight, that
// op's result is dropped when it finishes.
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   flush_i        discard queued results and the in-flight op
//   issue_valid_i  divide accepted by the divider (start pulse)
//   issue_tag_i    user tag of the issued op
//   issue_allow_o  credit: upstream may issue this cycle
//   div_finish_i   divider finish pulse
//   div_res_i      divider result, valid with div_finish_i
//   out_valid_o    head entry valid
//   out_ready_i    consumer accepts head
//   out_result_o   head result
//   out_status_o   head status {NV,DZ,OF,UF,NX}
//   out_tag_o      head tag
//   count_o        number of occupied entries
//   busy_o         op in flight or queue non-empty
//   err_o          sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------------------------
module fphub_div_result_queue #(
   parameter int unsigned E     = 5,
   parameter int unsigned M     = 10,
   parameter int unsigned WIDTH = E + M + 1,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 4,
   // Derived widths; not meant to be overridden
   parameter int unsigned CNT_W = $clog2(DEPTH + 1),
   parameter int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             issue_valid_i,
   input  logic [TAG_W-1:0] issue_tag_i,
   output logic             issue_allow_o,
   input  logic             div_finish_i,
   input  logic [WIDTH-1:0] div_res_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] out_result_o,
   output logic [4:0]       out_status_o,
   output logic [TAG_W-1:0] out_tag_o,
   output logic [CNT_W-1:0] count_o,
   output logic             busy_o,
   output logic             err_o
);

   // ------------------------------------------------------------------------------------------
   // Tracker FSM
   // ------------------------------------------------------------------------------------------
   // StWait: op in flight, its result is kept.
   // StDrop: op in flight, but a flush came after issue, so its result is discarded.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StWait = 2'd1,
      StDrop = 2'd2
   } trk_state_e;

   trk_state_e       state_q, state_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             issue_bad;

   always_comb begin
      state_d   = state_q;
      tag_d     = tag_q;
      issue_bad = 1'b0;
      case (state_q)
         StIdle: begin
            // An issue that arrives with a flush is a new op, so it is still accepted.
            if (issue_valid_i) begin
               state_d = StWait;
               tag_d   = issue_tag_i;
            end
         end
         StWait: begin
            if (div_finish_i) begin
               // A back-to-back issue reuses the slot that the finishing op frees.
               if (issue_valid_i) begin
                  state_d = StWait;
                  tag_d   = issue_tag_i;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               issue_bad = issue_valid_i;
               if (flush_i) begin
                  state_d = StDrop;
               end
            end
         end
         StDrop: begin
            if (div_finish_i) begin
               if (issue_valid_i) begin
                  state_d = StWait;
                  tag_d   = issue_tag_i;
               end else begin
                  state_d = StIdle;
               end
            end else begin
               issue_bad = issue_valid_i;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // The tag only has meaning while an op is in flight, so it needs no reset.
   always_ff @(posedge clk_i) begin
      tag_q <= tag_d;
   end

   // ------------------------------------------------------------------------------------------
   // Status flags derived from the raw result (sign bit excluded)
   // ------------------------------------------------------------------------------------------
   logic       flag_of;
   logic       flag_uf;
   logic [4:0] new_status;

   assign flag_of    = &div_res_i[E+M-1:0];
   assign flag_uf    = ~|div_res_i[E+M-1:0];
   assign new_status = {1'b0, 1'b0, flag_of, flag_uf, 1'b0};

   // ------------------------------------------------------------------------------------------
   // Queue control
   // ------------------------------------------------------------------------------------------
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             err_q, err_d;

   logic full;
   logic push_req;
   logic push;
   logic pop;
   logic finish_idle;

   assign full        = (count_q == CNT_W'(DEPTH));
   assign push_req    = div_finish_i && (state_q == StWait) && !flush_i;
   // A push into a full queue can only follow a credit violation; that entry is dropped.
   assign push        = push_req && !full;
   // A pop in a flush cycle is ignored because the flush empties the queue.
   assign pop         = out_valid_o && out_ready_i && !flush_i;
   assign finish_idle = div_finish_i && (state_q == StIdle);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q | finish_idle | issue_bad | (push_req && full);

      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Storage: written on push, not reset (contents are don't-care while empty)
   // ------------------------------------------------------------------------------------------
   logic [WIDTH-1:0] mem_res    [DEPTH];
   logic [4:0]       mem_status [DEPTH];
   logic [TAG_W-1:0] mem_tag    [DEPTH];

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_res[wr_ptr_q]    <= div_res_i;
         mem_status[wr_ptr_q] <= new_status;
         mem_tag[wr_ptr_q]    <= tag_q;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------------------------
   logic [CNT_W:0] occupancy;

   // The in-flight op, including one being dropped, holds a slot until it finishes.
   assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q != StIdle)};

   assign issue_allow_o = (occupancy < (CNT_W + 1)'(DEPTH));
   assign out_valid_o   = (count_q != '0);
   assign out_result_o  = mem_res[rd_ptr_q];
   assign out_status_o  = mem_status[rd_ptr_q];
   assign out_tag_o     = mem_tag[rd_ptr_q];
   assign count_o       = count_q;
   assign busy_o        = (state_q != StIdle) || (count_q != '0);
   assign err_o         = err_q;

endmodule
